// File: rtl/jt49.sv
// jt49: YM2149 / AY-3-8910 compatible programmable sound generator.
// Three square-wave tone channels, a shared 17-bit LFSR noise source, a shared
// 32-step envelope, a 16-entry register file, two I/O ports and a log DAC per channel.
module jt49 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       sel,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [9:0] sound,
    output logic       sample,
    input  logic [7:0] IOA_in,
    input  logic [7:0] IOB_in,
    output logic [7:0] IOA_out,
    output logic [7:0] IOB_out
);

    logic [7:0]  r_regs [16];
    logic        r_div;
    logic [2:0]  r_pre8;
    logic [11:0] r_tcnt [3];
    logic [2:0]  r_tone;
    logic [5:0]  r_ncnt;
    logic [16:0] r_lfsr;
    logic [15:0] r_ecnt;
    logic [4:0]  r_estep;
    logic        r_ehold;
    logic        r_einv;
    logic        r_ezero;
    logic        r_t8_d;
    logic        r_sample;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_c;
    logic [9:0]  r_sound;

    logic        w_we;
    logic        w_r13_wr;
    logic        w_m;
    logic        w_t8;
    logic        w_ntick;
    logic        w_etick;
    logic [12:0] w_tp [3];
    logic [6:0]  w_np2;
    logic [16:0] w_ep;
    logic [4:0]  w_elvl;
    logic [4:0]  w_lvl [3];
    logic [7:0]  w_dac [3];

    function automatic logic [7:0] wr_mask(input logic [3:0] a);
        logic [7:0] m;
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: m = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: m = 8'h1F;
            default:                 m = 8'hFF;
        endcase
        return m;
    endfunction

    // 12-bit period with 0 treated as 1, widened for an overflow-free compare
    function automatic logic [12:0] tone_period(input logic [3:0] hi, input logic [7:0] lo);
        logic [12:0] p;
        p = {1'b0, hi, lo};
        if (p == 13'd0) p = 13'd1;
        return p;
    endfunction

    function automatic logic [4:0] chan_level(input logic tone, input logic noise,
                                              input logic tdis, input logic ndis,
                                              input logic [4:0] amp, input logic [4:0] env);
        logic [4:0] lvl;
        if (amp[4])                lvl = env;
        else if (amp[3:0] == 4'd0) lvl = 5'd0;
        else                       lvl = {amp[3:0], 1'b1};
        if (((tone | tdis) & (noise | ndis)) == 1'b0) lvl = 5'd0;
        return lvl;
    endfunction

    // 1.5 dB per step below full scale, fractional part truncated
    function automatic logic [7:0] dac(input logic [4:0] lvl);
        logic [7:0] v;
        case (lvl)
            5'd0:  v = 8'd0;   5'd1:  v = 8'd1;   5'd2:  v = 8'd1;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd2;   5'd5:  v = 8'd2;   5'd6:  v = 8'd3;   5'd7:  v = 8'd4;
            5'd8:  v = 8'd4;   5'd9:  v = 8'd5;   5'd10: v = 8'd6;   5'd11: v = 8'd8;
            5'd12: v = 8'd9;   5'd13: v = 8'd11;  5'd14: v = 8'd13;  5'd15: v = 8'd16;
            5'd16: v = 8'd19;  5'd17: v = 8'd22;  5'd18: v = 8'd27;  5'd19: v = 8'd32;
            5'd20: v = 8'd38;  5'd21: v = 8'd45;  5'd22: v = 8'd53;  5'd23: v = 8'd64;
            5'd24: v = 8'd76;  5'd25: v = 8'd90;  5'd26: v = 8'd107; 5'd27: v = 8'd127;
            5'd28: v = 8'd151; 5'd29: v = 8'd180; 5'd30: v = 8'd214;
            default: v = 8'd255;
        endcase
        return v;
    endfunction

    // Strobes, effective periods and per-channel levels
    always_comb begin
        w_we     = !cs_n && !wr_n;
        w_r13_wr = w_we && (addr == 4'd13);
        w_m      = clk_en && (sel || r_div);
        w_t8     = w_m && (r_pre8 == 3'd7);
        w_tp[0]  = tone_period(r_regs[1][3:0], r_regs[0]);
        w_tp[1]  = tone_period(r_regs[3][3:0], r_regs[2]);
        w_tp[2]  = tone_period(r_regs[5][3:0], r_regs[4]);
        w_np2    = {1'b0, r_regs[6][4:0], 1'b0};
        if (w_np2 == 7'd0) w_np2 = 7'd2;
        w_ep     = {1'b0, r_regs[12], r_regs[11]};
        if (w_ep == 17'd0) w_ep = 17'd1;
        w_ntick  = ({1'b0, r_ncnt} + 7'd1) >= w_np2;
        w_etick  = ({1'b0, r_ecnt} + 17'd1) >= w_ep;
        if (r_ezero)                      w_elvl = 5'd0;
        else if (r_regs[13][2] ^ r_einv) w_elvl = r_estep;
        else                              w_elvl = ~r_estep;
        w_lvl[0] = chan_level(r_tone[0], r_lfsr[0], r_regs[7][0], r_regs[7][3],
                              r_regs[8][4:0], w_elvl);
        w_lvl[1] = chan_level(r_tone[1], r_lfsr[0], r_regs[7][1], r_regs[7][4],
                              r_regs[9][4:0], w_elvl);
        w_lvl[2] = chan_level(r_tone[2], r_lfsr[0], r_regs[7][2], r_regs[7][5],
                              r_regs[10][4:0], w_elvl);
        w_dac[0] = dac(w_lvl[0]);
        w_dac[1] = dac(w_lvl[1]);
        w_dac[2] = dac(w_lvl[2]);
    end

    // Read mux: ports configured as inputs read their pins
    always_comb begin
        dout = r_regs[addr];
        if (addr == 4'd14 && !r_regs[7][6]) dout = IOA_in;
        if (addr == 4'd15 && !r_regs[7][7]) dout = IOB_in;
    end

    // CPU register writes, independent of the PSG clock enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
        end else if (w_we) begin
            r_regs[addr] <= din & wr_mask(addr);
        end
    end

    // Master divider and divide-by-8 prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= 1'b0;
            r_pre8 <= 3'd0;
        end else begin
            if (clk_en) r_div <= ~r_div;
            if (w_m)    r_pre8 <= r_pre8 + 3'd1;
        end
    end

    // Tone counters; a shortened period takes effect at the next compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) r_tcnt[i] <= 12'd0;
            r_tone <= 3'b000;
        end else if (w_t8) begin
            for (int i = 0; i < 3; i++) begin
                if (({1'b0, r_tcnt[i]} + 13'd1) >= w_tp[i]) begin
                    r_tcnt[i] <= 12'd0;
                    r_tone[i] <= ~r_tone[i];
                end else begin
                    r_tcnt[i] <= r_tcnt[i] + 12'd1;
                end
            end
        end
    end

    // Noise prescaler and LFSR (x^17 + x^14)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ncnt <= 6'd0;
            r_lfsr <= 17'h1;
        end else if (w_t8) begin
            if (w_ntick) begin
                r_ncnt <= 6'd0;
                r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            end else begin
                r_ncnt <= r_ncnt + 6'd1;
            end
        end
    end

    // Envelope prescaler and step sequencer; an R13 write beats a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ecnt  <= 16'd0;
            r_estep <= 5'd0;
            r_ehold <= 1'b0;
            r_einv  <= 1'b0;
            r_ezero <= 1'b0;
        end else if (w_r13_wr) begin
            r_ecnt  <= 16'd0;
            r_estep <= 5'd0;
            r_ehold <= 1'b0;
            r_einv  <= 1'b0;
            r_ezero <= 1'b0;
        end else if (w_t8) begin
            if (!w_etick) begin
                r_ecnt <= r_ecnt + 16'd1;
            end else begin
                r_ecnt <= 16'd0;
                if (!r_ehold) begin
                    if (r_estep != 5'd31) begin
                        r_estep <= r_estep + 5'd1;
                    end else if (!r_regs[13][3]) begin
                        r_ehold <= 1'b1;
                        r_ezero <= 1'b1;
                    end else if (r_regs[13][0]) begin
                        r_ehold <= 1'b1;
                        r_einv  <= r_einv ^ r_regs[13][1];
                    end else begin
                        r_estep <= 5'd0;
                        r_einv  <= r_einv ^ r_regs[13][1];
                    end
                end
            end
        end
    end

    // Output stage, refreshed the clk after each t8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t8_d   <= 1'b0;
            r_sample <= 1'b0;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_c      <= 8'd0;
            r_sound  <= 10'd0;
        end else begin
            r_t8_d   <= w_t8;
            r_sample <= r_t8_d;
            if (r_t8_d) begin
                r_a     <= w_dac[0];
                r_b     <= w_dac[1];
                r_c     <= w_dac[2];
                r_sound <= {2'b00, w_dac[0]} + {2'b00, w_dac[1]} + {2'b00, w_dac[2]};
            end
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign C       = r_c;
    assign sound   = r_sound;
    assign sample  = r_sample;
    assign IOA_out = r_regs[14];
    assign IOB_out = r_regs[15];

endmodule

// File: tb/tb_jt49.sv
// tb_jt49: self-checking bench for jt49 with a table of register vectors, hand sequences
// for tone/noise/envelope corners and a randomized run against a behavioural model.
module tb_jt49;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       sel;
    logic       cs_n;
    logic       wr_n;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic [9:0] sound;
    logic       sample;
    logic [7:0] IOA_in;
    logic [7:0] IOB_in;
    logic [7:0] IOA_out;
    logic [7:0] IOB_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int dac_tbl [32];
    int nz [512];
    int first20 [20];
    int mreg [16];

    // Configuration of the current randomized run, read by the model
    int m_tp [3];
    int m_amp [3];
    int m_np;
    int m_ep;
    int m_r7;
    int m_shape;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] rd;
    } reg_vec_t;
    reg_vec_t vecs [16];

    jt49 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .sel     (sel),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .A       (A),
        .B       (B),
        .C       (C),
        .sound   (sound),
        .sample  (sample),
        .IOA_in  (IOA_in),
        .IOB_in  (IOB_in),
        .IOA_out (IOA_out),
        .IOB_out (IOB_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mask_of(input int a);
        if (a == 1 || a == 3 || a == 5 || a == 13) return 15;
        if (a == 6 || a == 8 || a == 9 || a == 10) return 31;
        return 255;
    endfunction

    // Envelope level after s steps, straight from the shape description
    function automatic int env_level(input int shape, input int s);
        int cyc_n, pos, fin;
        bit cont, att, alt, hold;
        cont  = shape[3];
        att   = shape[2];
        alt   = shape[1];
        hold  = shape[0];
        cyc_n = s / 32;
        pos   = s % 32;
        if (cyc_n == 0) return att ? pos : 31 - pos;
        if (!cont) return 0;
        if (hold) begin
            fin = att ? 31 : 0;
            return alt ? 31 - fin : fin;
        end
        if (alt) return (att ^ cyc_n[0]) ? pos : 31 - pos;
        return att ? pos : 31 - pos;
    endfunction

    // Expected DAC value of channel i after k t8 ticks
    function automatic int exp_chan(input int i, input int k);
        int tpe, npe, epe, tone, noise, tdis, ndis, amp, lvl;
        tpe   = (m_tp[i] == 0) ? 1 : m_tp[i];
        npe   = (m_np == 0) ? 1 : m_np;
        epe   = (m_ep == 0) ? 1 : m_ep;
        tone  = (k / tpe) % 2;
        noise = nz[k / (2 * npe)];
        tdis  = (m_r7 >> i) & 1;
        ndis  = (m_r7 >> (i + 3)) & 1;
        amp   = m_amp[i];
        if ((amp & 16) != 0)     lvl = env_level(m_shape, k / epe);
        else if ((amp & 15) == 0) lvl = 0;
        else                      lvl = (amp & 15) * 2 + 1;
        if (((tone | tdis) & (noise | ndis)) == 0) lvl = 0;
        return dac_tbl[lvl];
    endfunction

    task automatic do_reset();
        clk_en = 1'b0;
        sel    = 1'b1;
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        addr   = 4'd0;
        din    = 8'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr = a;
        din  = d;
        cs_n = 1'b0;
        wr_n = 1'b0;
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input int exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    // Returns just after the clock edge that raised sample; bounded wait
    task automatic wait_sample(input bit rnd_en, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 400) begin
            @(posedge clk);
            #1;
            if (sample) ok = 1'b1;
            if (rnd_en) clk_en = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (!ok) check("sample_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int last, lfsr, nb, a, d, exp;

        rst_n  = 1'b1;
        IOA_in = 8'h00;
        IOB_in = 8'h00;
        dac_tbl[0] = 0;
        for (int n = 1; n < 32; n++)
            dac_tbl[n] = int'($floor(255.0 * $pow(10.0, -1.5 * real'(31 - n) / 20.0)));
        lfsr = 1;
        for (int i = 0; i < 512; i++) begin
            nz[i] = lfsr & 1;
            nb    = (lfsr ^ (lfsr >> 3)) & 1;
            lfsr  = (lfsr >> 1) | (nb << 16);
        end
        for (int i = 0; i < 20; i++) first20[i] = (i == 0 || i == 17) ? 1 : 0;

        vecs[0]  = '{4'd7,  8'hC0, 8'hC0};
        vecs[1]  = '{4'd0,  8'hA5, 8'hA5};
        vecs[2]  = '{4'd1,  8'hFF, 8'h0F};
        vecs[3]  = '{4'd2,  8'h7E, 8'h7E};
        vecs[4]  = '{4'd3,  8'hF3, 8'h03};
        vecs[5]  = '{4'd4,  8'h81, 8'h81};
        vecs[6]  = '{4'd5,  8'hAB, 8'h0B};
        vecs[7]  = '{4'd6,  8'hFF, 8'h1F};
        vecs[8]  = '{4'd8,  8'hFF, 8'h1F};
        vecs[9]  = '{4'd9,  8'hE5, 8'h05};
        vecs[10] = '{4'd10, 8'h3C, 8'h1C};
        vecs[11] = '{4'd11, 8'h12, 8'h12};
        vecs[12] = '{4'd12, 8'h34, 8'h34};
        vecs[13] = '{4'd13, 8'hFF, 8'h0F};
        vecs[14] = '{4'd14, 8'h5A, 8'h5A};
        vecs[15] = '{4'd15, 8'hC3, 8'hC3};

        // Reset state
        do_reset();
        for (int r = 0; r < 16; r++) rd_chk($sformatf("reset_r%0d", r), 4'(r), 0);
        check("reset_A", A, 0);
        check("reset_B", B, 0);
        check("reset_C", C, 0);
        check("reset_sound", sound, 0);
        check("reset_ioa", IOA_out, 0);
        check("reset_iob", IOB_out, 0);

        // Register masks and I/O port direction, table-driven
        IOA_in = 8'h11;
        IOB_in = 8'h22;
        for (int i = 0; i < 16; i++) wr(vecs[i].a, vecs[i].d);
        for (int i = 0; i < 16; i++)
            rd_chk($sformatf("regtbl_r%0d", vecs[i].a), vecs[i].a, vecs[i].rd);
        check("ioa_out", IOA_out, 8'h5A);
        check("iob_out", IOB_out, 8'hC3);
        wr(4'd7, 8'h00);
        rd_chk("r14_in_r7_00", 4'd14, 8'h11);
        rd_chk("r15_in_r7_00", 4'd15, 8'h22);
        wr(4'd7, 8'h40);
        rd_chk("r14_out_r7_40", 4'd14, 8'h5A);
        rd_chk("r15_in_r7_40", 4'd15, 8'h22);
        wr(4'd7, 8'h80);
        rd_chk("r14_in_r7_80", 4'd14, 8'h11);
        rd_chk("r15_out_r7_80", 4'd15, 8'hC3);

        // Random register traffic against a register-file model
        do_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        for (int it = 0; it < 80; it++) begin
            a = $urandom_range(0, 15);
            d = $urandom_range(0, 255);
            IOA_in = 8'($urandom_range(0, 255));
            IOB_in = 8'($urandom_range(0, 255));
            wr(4'(a), 8'(d));
            mreg[a] = d & mask_of(a);
            a = $urandom_range(0, 15);
            exp = mreg[a];
            if (a == 14 && ((mreg[7] >> 6) & 1) == 0) exp = IOA_in;
            if (a == 15 && ((mreg[7] >> 7) & 1) == 0) exp = IOB_in;
            rd_chk($sformatf("rndreg_r%0d", a), 4'(a), exp);
        end
        check("rndreg_ioa", IOA_out, mreg[14]);
        check("rndreg_iob", IOB_out, mreg[15]);

        // Tone A at TP=1: 16-clk period with sel=1, 32 clks with sel=0
        do_reset();
        wr(4'd0, 8'h01);
        wr(4'd1, 8'h00);
        wr(4'd7, 8'h3E);
        wr(4'd8, 8'h0F);
        clk_en = 1'b1;
        last = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_sample(1'b0, ok);
            check($sformatf("tone_A_k%0d", k), A, (k % 2 == 1) ? 255 : 0);
            check($sformatf("tone_sound_k%0d", k), sound, (k % 2 == 1) ? 255 : 0);
            if (k > 1) check("tone_sample_interval", cyc - last, 8);
            last = cyc;
        end
        sel = 1'b0;
        wait_sample(1'b0, ok);
        last = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_sample(1'b0, ok);
            check("div2_sample_interval", cyc - last, 16);
            last = cyc;
        end

        // Noise on A, NP=0: shift every 2 t8, first 20 bits of the seeded sequence
        do_reset();
        wr(4'd6, 8'h00);
        wr(4'd7, 8'h37);
        wr(4'd8, 8'h0F);
        clk_en = 1'b1;
        for (int k = 1; k < 40; k++) begin
            wait_sample(1'b0, ok);
            check($sformatf("noise_k%0d", k), A, first20[k / 2] * 255);
        end

        // Envelope attack+hold ramp, restart and restart colliding with a tick
        do_reset();
        wr(4'd7, 8'h3F);
        wr(4'd8, 8'h10);
        wr(4'd11, 8'h01);
        wr(4'd12, 8'h00);
        wr(4'd13, 8'h0D);
        clk_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            wait_sample(1'b0, ok);
            check($sformatf("env_ramp_k%0d", k), A, dac_tbl[(k < 31) ? k : 31]);
        end
        wr(4'd13, 8'h0D);
        for (int k = 1; k <= 4; k++) begin
            wait_sample(1'b0, ok);
            check($sformatf("env_restart_k%0d", k), A, dac_tbl[k]);
        end
        repeat (6) @(posedge clk);
        #1;
        wr(4'd13, 8'h0D);
        for (int k = 0; k < 3; k++) begin
            wait_sample(1'b0, ok);
            check($sformatf("env_collide_k%0d", k), A, dac_tbl[k]);
        end

        // Randomized configurations against the behavioural model
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                m_tp[i]  = $urandom_range(0, 4);
                m_amp[i] = ($urandom_range(0, 2) == 0) ? 16 : $urandom_range(0, 15);
            end
            m_np    = $urandom_range(0, 3);
            m_ep    = $urandom_range(0, 2);
            m_r7    = $urandom_range(0, 63);
            m_shape = $urandom_range(0, 15);
            wr(4'd0, 8'(m_tp[0]));
            wr(4'd2, 8'(m_tp[1]));
            wr(4'd4, 8'(m_tp[2]));
            wr(4'd6, 8'(m_np));
            wr(4'd7, 8'(m_r7));
            wr(4'd8, 8'(m_amp[0]));
            wr(4'd9, 8'(m_amp[1]));
            wr(4'd10, 8'(m_amp[2]));
            wr(4'd11, 8'(m_ep));
            wr(4'd13, 8'(m_shape));
            sel    = 1'($urandom_range(0, 1));
            clk_en = 1'b1;
            ok     = 1'b1;
            for (int k = 1; k <= 96 && ok; k++) begin
                wait_sample(1'b1, ok);
                if (ok) begin
                    check($sformatf("rnd%0d_k%0d_A", t, k), A, exp_chan(0, k));
                    check($sformatf("rnd%0d_k%0d_B", t, k), B, exp_chan(1, k));
                    check($sformatf("rnd%0d_k%0d_C", t, k), C, exp_chan(2, k));
                    check($sformatf("rnd%0d_k%0d_snd", t, k), sound,
                          exp_chan(0, k) + exp_chan(1, k) + exp_chan(2, k));
                end
            end
        end

        // Full-scale mix, then asynchronous reset mid-run
        do_reset();
        wr(4'd7, 8'h3F);
        wr(4'd8, 8'h0F);
        wr(4'd9, 8'h0F);
        wr(4'd10, 8'h0F);
        clk_en = 1'b1;
        wait_sample(1'b0, ok);
        check("full_A", A, 255);
        check("full_B", B, 255);
        check("full_C", C, 255);
        check("full_sound", sound, 765);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_sound", sound, 0);
        check("async_rst_A", A, 0);
        addr = 4'd8;
        #1;
        check("async_rst_r8", dout, 0);
        #2 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
